mult_booth_param: RTL and testbench

Parametrised radix-2 Booth sequential multiplier; next generation of the fixed 32-bit mult unit feeding HI/LO in the datapath. Adds configurable operand width, a per-operation signed/unsigned mode (MULT/MULTU), and a busy flag. Start requests are ignored while busy. One Booth step per clock; result registered into HI/LO with a one-cycle done pulse.

---
 rtl/mult_pkg.sv | 33 +++
 rtl/booth_step.sv | 33 +++
 rtl/mult_booth_param.sv | 94 +++++++++
 tb/tb_mult_booth_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_pkg : shared types and helpers for the Booth multiplier  | rev 1.0
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Extension bit used to widen an operand by one bit for the signed datapath.
    function automatic logic ext_bit(input logic msb, input logic is_signed);
        return msb & is_signed;
    endfunction

    function automatic booth_op_t booth_decode(input logic [1:0] q_pair);
        case (q_pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_step : one radix-2 Booth add/sub plus arithmetic shift  | rev 1.0
// ---------------------------------------------------------------------------
module booth_step
    import mult_pkg::*;
#(
    parameter int N = 33
) (
    input  logic [2*N:0] acc,
    input  logic [N-1:0] mcand,
    output logic [2*N:0] acc_next
);

    logic [N-1:0] a_part;
    logic [N-1:0] sum;
    booth_op_t    op;

    always_comb begin
        op     = booth_decode(acc[1:0]);
        a_part = acc[2*N:N+1];
        sum    = a_part;
        case (op)
            BOOTH_ADD: sum = a_part + mcand;
            BOOTH_SUB: sum = a_part - mcand;
            default:   sum = a_part;
        endcase
        // Shift {A,Q,Q-1} right by one; the old Q-1 falls off the bottom.
        acc_next = {sum[N-1], sum, acc[N:1]};
    end

endmodule
`default_nettype wire

// File: rtl/mult_booth_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_booth_param : sequential radix-2 Booth multiplier, signed/unsigned  | rev 1.0
// ---------------------------------------------------------------------------
module mult_booth_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             MultSigned,
    input  logic [WIDTH-1:0] RegAOut,
    input  logic [WIDTH-1:0] RegBOut,
    output logic             MultDone,
    output logic             MultBusy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int N     = WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int ACC_W = 2 * N + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   counter;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_step;
    logic [N-1:0]       mcand;

    booth_step #(.N(N)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (MultCtrl) state_next = CALC;
            CALC:    if (counter == LAST_STEP) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The done pulse and HI/LO land on the edge that leaves FINISH, so the
    // following IDLE edge can already accept a new start (N+2 cycle cadence).
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter  <= '0;
            acc      <= '0;
            mcand    <= '0;
            HI       <= '0;
            LO       <= '0;
            MultDone <= 1'b0;
            MultBusy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    MultDone <= 1'b0;
                    MultBusy <= MultCtrl;
                    if (MultCtrl) begin
                        mcand   <= {ext_bit(RegAOut[WIDTH-1], MultSigned), RegAOut};
                        acc     <= {{N{1'b0}}, ext_bit(RegBOut[WIDTH-1], MultSigned),
                                    RegBOut, 1'b0};
                        counter <= '0;
                    end
                end
                CALC: begin
                    acc     <= acc_step;
                    counter <= counter + 1'b1;
                end
                FINISH: begin
                    HI       <= acc[2*WIDTH:WIDTH+1];
                    LO       <= acc[WIDTH:1];
                    MultDone <= 1'b1;
                    MultBusy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_booth_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_booth_param : directed table-driven bench for the Booth multiplier  | rev 1.0
// ---------------------------------------------------------------------------
module tb_mult_booth_param;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl = 1'b0, sgn = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        done, busy;
    logic [31:0] hi, lo;

    logic        ctrl8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        done8, busy8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_booth_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .MultCtrl(ctrl), .MultSigned(sgn),
        .RegAOut(a), .RegBOut(b), .MultDone(done), .MultBusy(busy),
        .HI(hi), .LO(lo)
    );

    mult_booth_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .MultCtrl(ctrl8), .MultSigned(sgn8),
        .RegAOut(a8), .RegBOut(b8), .MultDone(done8), .MultBusy(busy8),
        .HI(hi8), .LO(lo8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic start32(input logic s, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        ctrl = 1'b1; sgn = s; a = x; b = y;
        @(posedge clk);
        #1 ctrl = 1'b0;
    endtask

    // Edges counted from the start edge; -1 on timeout.
    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    vec_t vecs[9];
    int   cyc;
    int   ndone;
    int   t_first, t_second;
    logic [31:0] lo_seen;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
        vecs[1] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[2] = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_done_busy", {62'h0, done, busy}, 64'h0);
        @(negedge clk) reset = 1'b1;

        foreach (vecs[i]) begin
            start32(vecs[i].sgn, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_after_start", i), 64'(busy), 64'h1);
            wait_done(60, cyc);
            chk($sformatf("v%0d_latency", i), 64'(cyc), 64'd34);
            chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'h1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle_after", i), {62'h0, done, busy}, 64'h0);
        end

        // 8-bit instance: -128 * 127
        @(negedge clk);
        ctrl8 = 1'b1; sgn8 = 1'b1; a8 = 8'h80; b8 = 8'h7F;
        @(posedge clk);
        #1 ctrl8 = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                cyc = i;
                break;
            end
        end
        chk("w8_latency", 64'(cyc), 64'd10);
        chk("w8_hi", 64'(hi8), 64'hC0);
        chk("w8_lo", 64'(lo8), 64'h80);

        // Start requests during CALC are ignored
        start32(1'b1, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        ctrl = 1'b1; a = 32'd7; b = 32'd7;
        @(negedge clk);
        ctrl = 1'b0;
        ndone = 0;
        lo_seen = '0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                lo_seen = lo;
            end
        end
        chk("ignore_ndone", 64'(ndone), 64'd1);
        chk("ignore_lo", 64'(lo_seen), 64'd6);

        // MultCtrl held high: back-to-back results
        @(negedge clk);
        ctrl = 1'b1; sgn = 1'b1; a = 32'd2; b = 32'd3;
        t_first = -1;
        t_second = -1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
            end
        end
        chk("held_seen_two", 64'(t_second >= 0), 64'h1);
        chk("held_period", 64'(t_second - t_first), 64'd35);
        @(negedge clk) ctrl = 1'b0;
        repeat (40) @(posedge clk);

        // Mid-operation reset aborts
        start32(1'b1, 32'd5, 32'd5);
        repeat (8) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_done_busy", {62'h0, done, busy}, 64'h0);
        @(negedge clk) reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort_no_activity", 64'(ndone), 64'd0);

        start32(1'b1, 32'd4, 32'd4);
        wait_done(60, cyc);
        chk("post_abort_latency", 64'(cyc), 64'd34);
        chk("post_abort_lo", 64'(lo), 64'h10);
        chk("post_abort_hi", 64'(hi), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
